// File: rtl/alu_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Holds the FSM state enum, the pass count and the control-word bit positions.
package alu_seq_pkg;

    localparam int NIBBLES = 4;

    localparam int C_EX = 5;
    localparam int C_NX = 4;
    localparam int C_EY = 3;
    localparam int C_NY = 2;
    localparam int C_F  = 1;
    localparam int C_NO = 0;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/alu_nibble_seq_alu4.sv
// Combinational 4-bit ALU slice (ex/nx/ey/ny gating, add or and, optional invert); zero latency, no flow control.
// The adder carry is produced even in AND mode so the chain stays uniform; the sequencer masks it.
module alu_nibble_seq_alu4
    import alu_seq_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [5:0] c,
    input  logic       carry_in,
    output logic [3:0] out,
    output logic       carry_out,
    output logic       nz_flag
);

    logic [3:0] ax;
    logic [3:0] ay;
    logic [3:0] f_res;
    logic [4:0] sum;

    always_comb begin
        ax = c[C_EX] ? x : 4'h0;
        if (c[C_NX]) ax = ~ax;
        ay = c[C_EY] ? y : 4'h0;
        if (c[C_NY]) ay = ~ay;
        sum       = {1'b0, ax} + {1'b0, ay} + {4'h0, carry_in};
        f_res     = c[C_F] ? sum[3:0] : (ax & ay);
        out       = c[C_NO] ? ~f_res : f_res;
        carry_out = sum[4];
        nz_flag   = |out;
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// 16-bit ALU run through one 4-bit slice over 4 clocks (done 4 clocks after accept); start ignored while busy.
// Optional V (overflow) output when ALU_SEQ_OVERFLOW_EN is defined.
module alu_nibble_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [5:0]  C,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry_out,
    output logic        Z,
`ifdef ALU_SEQ_OVERFLOW_EN
    output logic        V,
`endif
    output logic        N
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [5:0]  c_q;
    logic        cy_q;
    logic        nz_acc;
    logic [1:0]  idx;
    logic [3:0]  slice_out;
    logic        slice_co;
    logic        slice_nz;
    logic        accept;
    logic        last;

    alu_nibble_seq_alu4 u_alu4 (
        .x         (x_q[{idx, 2'b00} +: 4]),
        .y         (y_q[{idx, 2'b00} +: 4]),
        .c         (c_q),
        .carry_in  (cy_q),
        .out       (slice_out),
        .carry_out (slice_co),
        .nz_flag   (slice_nz)
    );

    assign busy   = (state == RUN);
    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (idx == 2'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    logic ax15;
    logic ay15;
    logic s15;

    // Sign bits after input gating, and the sum sign before the output invert.
    assign ax15 = (x_q[15] & c_q[C_EX]) ^ c_q[C_NX];
    assign ay15 = (y_q[15] & c_q[C_EY]) ^ c_q[C_NY];
    assign s15  = slice_out[3] ^ c_q[C_NO];

    always_ff @(posedge clk) begin
        if (reset)     V <= 1'b0;
        else if (last) V <= c_q[C_F] & (ax15 == ay15) & (s15 != ax15);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            c_q       <= '0;
            cy_q      <= 1'b0;
            nz_acc    <= 1'b0;
            idx       <= '0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            Z         <= 1'b1;
            N         <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                x_q    <= X;
                y_q    <= Y;
                c_q    <= C;
                cy_q   <= carry_in;
                nz_acc <= 1'b0;
                idx    <= '0;
            end
            if (state == RUN) begin
                result[{idx, 2'b00} +: 4] <= slice_out;
                cy_q   <= slice_co;
                nz_acc <= nz_acc | slice_nz;
                idx    <= idx + 2'd1;
            end
            // Flags are published only once the final nibble lands.
            if (last) begin
                Z         <= ~(nz_acc | slice_nz);
                N         <= slice_out[3];
                carry_out <= slice_co & c_q[C_F];
            end
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: word-level reference model checked every cycle, plus literal expectations per directed op.
module tb_alu_nibble_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] X;
    logic [15:0] Y;
    logic [5:0]  C;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        Z;
    logic        N;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic        V;
`endif

    alu_nibble_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .X         (X),
        .Y         (Y),
        .C         (C),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .Z         (Z),
`ifdef ALU_SEQ_OVERFLOW_EN
        .V         (V),
`endif
        .N         (N)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Whole-word reference: the 16-bit operation the four slice passes must add up to.
    task automatic alu_word(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c,
                            input logic ci, output logic [15:0] r, output logic co, output logic v);
        logic [15:0] ax;
        logic [15:0] ay;
        logic [15:0] s;
        logic [16:0] sum;
        ax  = c[5] ? x : 16'h0;
        if (c[4]) ax = ~ax;
        ay  = c[3] ? y : 16'h0;
        if (c[2]) ay = ~ay;
        sum = {1'b0, ax} + {1'b0, ay} + {16'h0, ci};
        s   = c[1] ? sum[15:0] : (ax & ay);
        r   = c[0] ? ~s : s;
        co  = c[1] & sum[16];
        v   = c[1] && (ax[15] == ay[15]) && (s[15] != ax[15]);
    endtask

    int          rem = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_res = 16'h0;
    logic        m_z = 1'b1, m_n = 1'b0, m_c = 1'b0, m_v = 1'b0;
    logic [15:0] p_res;
    logic        p_c, p_v;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            rem = 0;
            m_res = 16'h0; m_z = 1'b1; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
        end else if (rem == 0) begin
            if (start) begin
                alu_word(X, Y, C, carry_in, p_res, p_c, p_v);
                rem = 4;
            end
        end else begin
            rem--;
            if (rem == 0) begin
                m_done = 1'b1;
                m_res = p_res; m_z = (p_res == 16'h0); m_n = p_res[15]; m_c = p_c; m_v = p_v;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 16'(busy), 16'(rem != 0));
        check("done", 16'(done), 16'(m_done));
        check("Z", 16'(Z), 16'(m_z));
        check("N", 16'(N), 16'(m_n));
        check("carry_out", 16'(carry_out), 16'(m_c));
`ifdef ALU_SEQ_OVERFLOW_EN
        check("V", 16'(V), 16'(m_v));
`endif
        if (rem == 0) check("result", result, m_res);
    end

    task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                          input logic [5:0] c, input logic ci, input logic [15:0] er,
                          input logic ec, input logic ez, input logic en);
        int cnt;
        @(negedge clk);
        X = x; Y = y; C = c; carry_in = ci; start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            cnt++;
            if (done) break;
        end
        check({name, "_lat"}, 16'(cnt - 1), 16'd4);
        check({name, "_res"}, result, er);
        check({name, "_cout"}, 16'(carry_out), 16'(ec));
        check({name, "_Z"}, 16'(Z), 16'(ez));
        check({name, "_N"}, 16'(N), 16'(en));
        check({name, "_model"}, m_res, er);
    endtask

    initial begin
        int dones;
        int first_done;
        int second_done;
        reset = 1'b1; start = 1'b0; X = '0; Y = '0; C = '0; carry_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_result", result, 16'h0);
        check("rst_Z", 16'(Z), 16'd1);
        check("rst_N", 16'(N), 16'd0);
        check("rst_cout", 16'(carry_out), 16'd0);
        reset = 1'b0;

        run_op("add",    16'h1234, 16'h0FFF, 6'b101010, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op("addcy",  16'hFFFF, 16'h0001, 6'b101010, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("and",    16'hF0F0, 16'h3C3C, 6'b101000, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0);
        run_op("and_ci", 16'hF0F0, 16'h3C3C, 6'b101000, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0);
        run_op("sub",    16'h0005, 16'h0007, 6'b111011, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1);
        run_op("addci",  16'h00FF, 16'h0000, 6'b101010, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ_OVERFLOW_EN
        run_op("ovf",    16'h7FFF, 16'h0001, 6'b101010, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        check("ovf_V", 16'(V), 16'd1);
        run_op("noovf",  16'h1234, 16'h0FFF, 6'b101010, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        check("noovf_V", 16'(V), 16'd0);
`endif

        // start re-asserted on the two cycles after an accept must be dropped
        @(negedge clk);
        X = 16'h0001; Y = 16'h0002; C = 6'b101010; carry_in = 1'b0; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = (i < 2);
            if (i == 0) X = 16'hAAAA;
            if (done) begin
                dones++;
                check("ign_res", result, 16'h0003);
            end
        end
        check("ign_dones", 16'(dones), 16'd1);

        // start held high: one op every 5 clocks
        @(negedge clk);
        X = 16'h0100; Y = 16'h0100; C = 6'b101010; start = 1'b1;
        dones = 0; first_done = -1; second_done = -1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = (i < 9);
            if (done) begin
                dones++;
                if (first_done < 0) first_done = i; else second_done = i;
            end
        end
        check("b2b_dones", 16'(dones), 16'd2);
        check("b2b_spacing", 16'(second_done - first_done), 16'd5);
        check("b2b_res", result, 16'h0200);
        repeat (6) @(negedge clk);

        // reset while nibble 2 is on the slice
        @(negedge clk);
        X = 16'h1111; Y = 16'h2222; C = 6'b101010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        check("abort_result", result, 16'h0);
        check("abort_Z", 16'(Z), 16'd1);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_nodone", 16'(dones), 16'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
